// File: rtl/mc_control.sv
// Multi-cycle processor control unit: Moore FSM sequencing fetch, decode and
// per-instruction execution, plus a completed-instruction counter and a sticky illegal-opcode flag.
module mc_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSrc,
  output logic        pc_en,
  output logic [3:0]  state,
  output logic [15:0] instr_cnt,
  output logic        illegal
);

  // state  | meaning
  // FETCH  | read instruction at PC, PC <= PC+4
  // DECODE | register read, branch target into ALUOut, dispatch on opcode
  // MEMADR | compute lw/sw effective address
  // MEMRD  | read data memory at ALUOut
  // MEMWB  | write loaded data to rt
  // MEMWR  | write rt to data memory at ALUOut
  // EXEC   | R-type ALU operation
  // ALUWB  | write ALU result to rd
  // BRANCH | beq compare, PC <= target when zero
  // JUMP   | PC <= jump target
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_opcode;
  logic [15:0] r_instr_cnt;
  logic        r_illegal;
  logic        w_done;
  logic        w_illegal_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_opcode    <= 6'd0;
      r_instr_cnt <= 16'd0;
      r_illegal   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_opcode <= opcode;
      end
      if (w_illegal_op) begin
        r_illegal <= 1'b1;
      end
      if (w_done) begin
        r_instr_cnt <= r_instr_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_next       = S_FETCH;
    w_done       = 1'b0;
    w_illegal_op = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    PCSrc        = 2'b00;

    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next       = S_FETCH;
            w_illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // Only lw or sw can reach here, so anything but lw is a store.
        w_next  = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        w_done   = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        w_done   = 1'b1;
        w_next   = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        w_done   = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCSrc       = 2'b01;
        PCWriteCond = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        w_done  = 1'b1;
        w_next  = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  assign pc_en     = PCWrite | (PCWriteCond & zero);
  assign state     = r_state;
  assign instr_cnt = r_instr_cnt;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_mc_control.sv
// Randomized self-checking bench for mc_control: each instruction's expected
// state walk and per-state control word come from the instruction-level behaviour.
module tb_mc_control;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg;
  logic        RegWrite, ALUSrcA, PCWrite, PCWriteCond;
  logic [1:0]  ALUSrcB, ALUOp, PCSrc;
  logic        pc_en;
  logic [3:0]  state;
  logic [15:0] instr_cnt;
  logic        illegal;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] cnt_m;
  logic        ill_m;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010;

  mc_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .pc_en(pc_en), .state(state), .instr_cnt(instr_cnt), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] ctl_act;
  assign ctl_act = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                    ALUSrcA, PCWrite, PCWriteCond, ALUSrcB, ALUOp, PCSrc};

  // Control word each state must present, field by field from the state table.
  function automatic logic [15:0] exp_ctl(input int s);
    logic iord, mrd, mwr, irw, rdst, m2r, rw, srca, pcw, pcwc;
    logic [1:0] srcb, aop, psrc;
    {iord, mrd, mwr, irw, rdst, m2r, rw, srca, pcw, pcwc} = '0;
    srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      0: begin mrd = 1; irw = 1; srcb = 2'b01; pcw = 1; end
      1: srcb = 2'b11;
      2: begin srca = 1; srcb = 2'b10; end
      3: begin mrd = 1; iord = 1; end
      4: begin m2r = 1; rw = 1; end
      5: begin mwr = 1; iord = 1; end
      6: begin srca = 1; aop = 2'b10; end
      7: begin rdst = 1; rw = 1; end
      8: begin srca = 1; aop = 2'b01; psrc = 2'b01; pcwc = 1; end
      9: begin psrc = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {iord, mrd, mwr, irw, rdst, m2r, rw, srca, pcw, pcwc, srcb, aop, psrc};
  endfunction

  function automatic logic [5:0] rand_illegal();
    logic [5:0] op;
    do op = 6'($urandom); while (op == LW || op == SW || op == RT || op == BEQ || op == JMP);
    return op;
  endfunction

  // Runs one instruction starting at a negedge in FETCH; ends at the negedge of the next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic zb, input string tag);
    int seq[$];
    bit is_ill;
    logic [15:0] ectl;
    logic epc;
    is_ill = 0;
    case (op)
      LW:      seq = '{0, 1, 2, 3, 4};
      SW:      seq = '{0, 1, 2, 5};
      RT:      seq = '{0, 1, 6, 7};
      BEQ:     seq = '{0, 1, 8};
      JMP:     seq = '{0, 1, 9};
      default: begin seq = '{0, 1}; is_ill = 1; end
    endcase
    foreach (seq[i]) begin
      opcode = (seq[i] == 1) ? op : 6'($urandom);
      zero   = (seq[i] == 8) ? zb : 1'($urandom);
      #1;
      compared++;
      if (state !== 4'(seq[i])) begin
        mismatched++;
        $display("FAIL %s state step %0d: got %0d want %0d", tag, i, state, seq[i]);
      end
      ectl = exp_ctl(seq[i]);
      compared++;
      if (ctl_act !== ectl) begin
        mismatched++;
        $display("FAIL %s ctl in state %0d: got %h want %h", tag, seq[i], ctl_act, ectl);
      end
      epc = ectl[7] | (ectl[6] & zero);
      compared++;
      if (pc_en !== epc) begin
        mismatched++;
        $display("FAIL %s pc_en in state %0d: got %b want %b", tag, seq[i], pc_en, epc);
      end
      @(negedge clk);
    end
    if (is_ill) ill_m = 1'b1;
    else cnt_m = cnt_m + 16'd1;
    compared++;
    if (instr_cnt !== cnt_m) begin
      mismatched++;
      $display("FAIL %s instr_cnt: got %h want %h", tag, instr_cnt, cnt_m);
    end
    compared++;
    if (illegal !== ill_m) begin
      mismatched++;
      $display("FAIL %s illegal: got %b want %b", tag, illegal, ill_m);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    opcode = 6'd0;
    zero   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cnt_m = 16'd0;
    ill_m = 1'b0;
    compared++;
    if ({state, pc_en, instr_cnt, illegal} !== {4'd0, 1'b1, 16'd0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset status: got st=%0d pc_en=%b cnt=%h ill=%b want 0/1/0000/0",
               state, pc_en, instr_cnt, illegal);
    end
    compared++;
    if (ctl_act !== exp_ctl(0)) begin
      mismatched++;
      $display("FAIL reset ctl: got %h want %h", ctl_act, exp_ctl(0));
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_instr(LW, 1'b0, "lw");
    run_instr(SW, 1'b1, "sw");
    run_instr(RT, 1'b0, "rtype");
    run_instr(BEQ, 1'b1, "beq_taken");
    run_instr(BEQ, 1'b0, "beq_not_taken");
    run_instr(6'b111111, 1'b0, "illegal_op");
    run_instr(JMP, 1'b0, "j_after_illegal");
  endtask

  task automatic test_random();
    logic [5:0] ops[6];
    ops = '{LW, SW, RT, BEQ, JMP, RT};
    for (int n = 0; n < 60; n++) begin
      int k;
      k = int'($urandom_range(0, 6));
      if (k == 6) run_instr(rand_illegal(), 1'($urandom), "rand_illegal");
      else run_instr(ops[k], 1'($urandom), "rand");
    end
  endtask

  task automatic test_reset_midinstr();
    opcode = LW;
    for (int c = 0; c < 3; c++) begin
      zero = 1'($urandom);
      @(negedge clk);
    end
    compared++;
    if (state !== 4'd3) begin
      mismatched++;
      $display("FAIL midreset reach MEMRD: got %0d want 3", state);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cnt_m = 16'd0;
    ill_m = 1'b0;
    compared++;
    if ({state, instr_cnt, illegal, RegWrite} !== {4'd0, 16'd0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL midreset status: got st=%0d cnt=%h ill=%b rw=%b want 0/0000/0/0",
               state, instr_cnt, illegal, RegWrite);
    end
    run_instr(LW, 1'b0, "lw_after_reset");
  endtask

  task automatic test_wrap();
    force dut.r_instr_cnt = 16'hFFFF;
    #1;
    release dut.r_instr_cnt;
    cnt_m = 16'hFFFF;
    compared++;
    if (instr_cnt !== 16'hFFFF) begin
      mismatched++;
      $display("FAIL wrap preload: got %h want ffff", instr_cnt);
    end
    run_instr(JMP, 1'b0, "wrap_j");
    run_instr(BEQ, 1'b1, "post_wrap_beq");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_midinstr();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port opcode, input, 6, instruction[31:26] from the instruction register.
REQ-004 SHALL have port zero, input, 1, ALU zero flag.
REQ-005 SHALL have 1-bit outputs, each active when 1: IorD (memory address select into the IorD mux: 0=PC, 1=ALUOut), MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCWrite and PCWriteCond.
REQ-006 SHALL have 2-bit outputs ALUSrcB, ALUOp and PCSrc.
REQ-007 SHALL have output pc_en, 1, equal to PCWrite OR (PCWriteCond AND zero).
REQ-008 SHALL have output state, 4, current state encoding for debug.
REQ-009 SHALL have output instr_cnt, 16, count of completed instructions.
REQ-010 SHALL have output illegal, 1, sticky flag set when an unsupported opcode is decoded.

Function
REQ-011 SHALL be a Moore FSM; all control outputs (REQ-005/006) are pure decodes of the state register, and any signal not listed for a state is 0.
REQ-012 SHALL use state encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9; codes 10-15 are unreachable and return to FETCH on the next edge with all outputs 0.
REQ-013 FETCH SHALL drive MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, PCWrite=1; next state DECODE.
REQ-014 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00, with next state selected by opcode: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 (R-type) -> EXEC; 000100 (beq) -> BRANCH; 000010 (j) -> JUMP; any other -> FETCH with illegal set.
REQ-015 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMRD if lw, MEMWR if sw (opcode as latched at DECODE).
REQ-016 MEMRD SHALL drive MemRead=1, IorD=1; next MEMWB.
REQ-017 MEMWB SHALL drive RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-018 MEMWR SHALL drive MemWrite=1, IorD=1; next FETCH.
REQ-019 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10; next ALUWB.
REQ-020 ALUWB SHALL drive RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
REQ-021 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCWriteCond=1; next FETCH regardless of zero.
REQ-022 JUMP SHALL drive PCSrc=10, PCWrite=1; next FETCH.
REQ-023 SHALL latch opcode into an internal register on the DECODE cycle; MEMADR branching uses only the latched value, so opcode changes after DECODE have no effect.
REQ-024 Cycle counts per instruction, FETCH through last state inclusive, SHALL be: lw=5, sw=4, R-type=4, beq=3, j=3, illegal=2.
REQ-025 instr_cnt SHALL increment by 1 on each edge leaving MEMWB, MEMWR, ALUWB, BRANCH or JUMP, and wrap 0xFFFF -> 0x0000; illegal-opcode returns do not increment it.
REQ-026 illegal SHALL stay set until reset.
REQ-027 MemRead and MemWrite SHALL never be 1 in the same cycle; IorD SHALL be 1 only in MEMRD/MEMWR.

Reset
REQ-028 When reset=1 at a rising edge: state<=FETCH, latched opcode<=0, instr_cnt<=0, illegal<=0; reset overrides all transitions.
REQ-029 After the reset edge, outputs SHALL equal FETCH decode (REQ-013), pc_en=1.
REQ-030 Reset asserted mid-instruction (e.g. in MEMRD) SHALL abandon it; no RegWrite or MemWrite pulse for that instruction follows the reset edge, and instr_cnt does not count it.
REQ-031 Before the first reset, state is undefined; no behaviour is required.

Verification
REQ-032 Reset, then opcode=100011 held -> state sequence 0,1,2,3,4,0; IorD=1 only in state 3; RegWrite=1 only in state 4; instr_cnt=1 after 5 edges.
REQ-033 opcode=101011 -> 0,1,2,5,0; MemWrite=1 only in state 5 with IorD=1; opcode=000000 -> 0,1,6,7,0 with ALUOp=10 in state 6, RegDst=1 in state 7.
REQ-034 opcode=000100, zero=1 in BRANCH -> pc_en=1 with PCSrc=01; repeat with zero=0 -> pc_en=0; both return to FETCH, instr_cnt +1 each.
REQ-035 opcode=111111 -> 0,1,0; illegal=1 and stays set through a following j (0,1,9,0); instr_cnt counts only the j.
REQ-036 Assert reset in MEMRD during lw -> next state FETCH, instr_cnt=0, no RegWrite pulse; preload 0xFFFF completions -> next completion yields instr_cnt=0x0000.
